sm_icache: RTL and testbench
============================

SM_ICACHE -- requirements
Module: sm_icache

Interface
REQ-001 The module SHALL have parameter LINES, default 8, meaning number of cache lines (power of two, ≥2).
REQ-002 The module SHALL have parameter WORDS, default 4, meaning 32-bit words per line (power of two, ≥2).
REQ-003 Port clk input 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n input 1: reset, asynchronous, active-low.
REQ-005 Port cpu_addr input 32: CPU fetch word address (pc>>2).
REQ-006 Port cpu_rdata output 32: instruction word for cpu_addr; valid only when cpu_ready=1.
REQ-007 Port cpu_ready output 1: 1 = hit, cpu_rdata valid this cycle; 0 = CPU SHALL stall.
REQ-008 Port flush input 1: invalidate all lines.
REQ-009 Port mem_req output 1: refill word request to instruction ROM.
REQ-010 Port mem_addr output 32: word address of requested refill word.
REQ-011 Port mem_ack input 1: mem_rdata valid for mem_addr this cycle (tie 1 for combinational ROM).
REQ-012 Port mem_rdata input 32: ROM read data.
REQ-013 Port miss_cnt output 16: saturating count of misses since reset.

Function
REQ-014 Address split SHALL be: offset = cpu_addr[log2(WORDS)-1:0], index = next log2(LINES) bits, tag = remaining upper bits.
REQ-015 Direct-mapped storage SHALL be one valid bit and one tag per line plus LINES*WORDS data words.
REQ-016 FSM states SHALL be IDLE and REFILL only.
REQ-017 In IDLE, hit = valid[index] && tag match, evaluated combinationally; cpu_ready=hit; cpu_rdata=data[index][offset] in the same cycle (zero-latency hit).
REQ-018 In IDLE on miss with flush=0, the FSM SHALL latch line base address (cpu_addr with offset zeroed), clear the word counter, increment miss_cnt (saturating at 0xFFFF), and go to REFILL next cycle.
REQ-019 In REFILL, mem_req=1, mem_addr=base+counter, cpu_ready=0.
REQ-020 Each cycle with mem_ack=1 SHALL write mem_rdata to data[latched index][counter] and increment counter; mem_ack=0 holds everything.
REQ-021 On the ack of word WORDS-1, the FSM SHALL write the latched tag, set valid[latched index], and return to IDLE; the re-presented address hits on that IDLE cycle.
REQ-022 Miss penalty with mem_ack tied 1 SHALL be exactly WORDS+1 cycles from miss detection to cpu_ready=1.
REQ-023 cpu_addr changes during REFILL SHALL be ignored; refill always completes for the latched line.
REQ-024 flush in IDLE SHALL clear all valid bits next edge; cpu_ready=0 that cycle and no refill starts.
REQ-025 flush in REFILL SHALL clear all valid bits, abandon refill (line left invalid), return to IDLE next edge.
REQ-026 A refill SHALL replace the victim line (tag overwrite); no other line is affected.
REQ-027 In IDLE, mem_req=0 and mem_addr=0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, all valid bits 0, counter 0, miss_cnt 0, mem_req 0, cpu_ready 0 (because no line valid).
REQ-029 Tag and data arrays SHALL NOT be reset.
REQ-030 Reset mid-REFILL SHALL discard the partial line; first post-reset fetch misses.

Structure
REQ-031 Package sm_icache_pkg SHALL hold the FSM state type and the index/offset/tag width derivation functions.
REQ-032 Data array SHALL be the sub-module sm_icache_data (LINES*WORDS x 32, one write port, one combinational read port).
REQ-033 Top-level integration SHALL place sm_icache between sm_cpu instruction port and sm_rom (mem_addr -> rom a, rom rd -> mem_rdata, mem_ack=1).

Verification
REQ-034 Cold fetch: reset, cpu_addr=0x00 -> cpu_ready=0 for 5 cycles, mem_addr 0,1,2,3, then cpu_ready=1 with ROM[0]; miss_cnt=1.
REQ-035 Same-line hits: after REQ-034, cpu_addr=1,2,3 -> cpu_ready=1 same cycle, data ROM[1..3], no mem_req, miss_cnt=1.
REQ-036 Conflict: fetch 0x00 then 0x20 (same index 0, LINES=8, WORDS=4) then 0x00 -> three misses, miss_cnt=3.
REQ-037 Backpressure: mem_ack low alternating cycles during refill of 0x04 -> mem_addr holds while ack=0; 9-cycle penalty; data correct.
REQ-038 Flush: flush pulse mid-REFILL (after word 1) -> FSM IDLE, next fetch of same address misses and refills all 4 words.
REQ-039 Async reset during REFILL -> outputs reset immediately without clk edge; subsequent fetch misses.

Source files
------------

// File: rtl/sm_icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// The FSM is two states, kept as plain constants so older netlists stay compatible.
package sm_icache_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_REFILL = 1'b1;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int words);
        return 32 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/sm_icache_data.sv
// Instruction data store: one synchronous write port, one combinational read port.
// Deliberately has no reset; contents are only meaningful behind a set valid bit.
module sm_icache_data #(
    parameter int LINES = 8,
    parameter int WORDS = 4,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [LINES*WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sm_icache.sv
// Direct-mapped instruction cache with zero-latency hits and a word-by-word line refill.
// The refill always finishes the latched line regardless of what the CPU presents meanwhile.
module sm_icache
    import sm_icache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] miss_cnt
);

    localparam int OW = off_bits(WORDS);
    localparam int IW = idx_bits(LINES);
    localparam int TW = tag_bits(LINES, WORDS);

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      base;
    logic [OW-1:0]    cnt;

    logic [OW-1:0] off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [IW-1:0] lidx;
    logic [TW-1:0] ltag;
    logic          idle;
    logic          hit;
    logic          last;
    logic          wr_en;

    assign off  = cpu_addr[OW-1:0];
    assign idx  = cpu_addr[OW+IW-1:OW];
    assign tag  = cpu_addr[31:OW+IW];
    assign lidx = base[OW+IW-1:OW];
    assign ltag = base[31:OW+IW];

    assign idle = (state == ST_IDLE);
    assign hit  = valid[idx] && (tags[idx] == tag);
    assign last = (cnt == OW'(WORDS-1));

    // A flush wins over both a hit and an in-flight refill word.
    assign cpu_ready = idle && hit && !flush;
    assign wr_en     = !idle && mem_ack && !flush;
    assign mem_req   = !idle;
    assign mem_addr  = idle ? '0 : (base + 32'(cnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            valid    <= '0;
            cnt      <= '0;
            base     <= '0;
            miss_cnt <= '0;
        end else if (idle) begin
            if (flush) begin
                valid <= '0;
            end else if (!hit) begin
                base  <= {cpu_addr[31:OW], {OW{1'b0}}};
                cnt   <= '0;
                state <= ST_REFILL;
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
        end else begin
            if (flush) begin
                valid <= '0;
                state <= ST_IDLE;
            end else if (mem_ack) begin
                cnt <= cnt + OW'(1);
                if (last) begin
                    valid[lidx] <= 1'b1;
                    state       <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && last) begin
            tags[lidx] <= ltag;
        end
    end

    sm_icache_data #(
        .LINES (LINES),
        .WORDS (WORDS),
        .AW    (IW + OW)
    ) u_data (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({lidx, cnt}),
        .wdata (mem_rdata),
        .raddr ({idx, off}),
        .rdata (cpu_rdata)
    );

endmodule

// File: tb/tb_sm_icache.sv
// Self-checking bench for sm_icache: a line-level cache model checked every cycle,
// directed scenarios with literal expectations, then a randomized fetch stream.
module tb_sm_icache;

    localparam int LINES = 8;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    assign mem_rdata = rom(mem_addr);

    sm_icache #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level model: which lines hold which tag, and the progress of an outstanding line fetch.
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    bit          refilling;
    logic [31:0] mbase;
    int          mgot;
    int          mmiss;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / WORDS) % LINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (WORDS * LINES);
    endfunction

    always @(negedge clk) begin : compare
        bit hitm;
        int li;
        if (!rst_n) begin
            checkOutput("rst_ready", 32'(cpu_ready), 32'd0);
            checkOutput("rst_req", 32'(mem_req), 32'd0);
            checkOutput("rst_maddr", mem_addr, 32'd0);
            checkOutput("rst_miss", 32'(miss_cnt), 32'd0);
            for (int i = 0; i < LINES; i++) begin
                mvalid[i] = 1'b0;
                mtag[i]   = '0;
            end
            refilling = 1'b0;
            mbase     = '0;
            mgot      = 0;
            mmiss     = 0;
        end else if (refilling) begin
            checkOutput("ref_ready", 32'(cpu_ready), 32'd0);
            checkOutput("ref_req", 32'(mem_req), 32'd1);
            checkOutput("ref_maddr", mem_addr, mbase + 32'(mgot));
            checkOutput("ref_miss", 32'(miss_cnt), 32'(mmiss));
            if (flush) begin
                for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
                refilling = 1'b0;
            end else if (mem_ack) begin
                mgot++;
                if (mgot == WORDS) begin
                    mvalid[line_of(mbase)] = 1'b1;
                    mtag[line_of(mbase)]   = tag_of(mbase);
                    refilling = 1'b0;
                end
            end
        end else begin
            li   = line_of(cpu_addr);
            hitm = mvalid[li] && (mtag[li] == tag_of(cpu_addr));
            checkOutput("idle_ready", 32'(cpu_ready), 32'(hitm && !flush));
            if (hitm && !flush) begin
                checkOutput("idle_rdata", cpu_rdata, rom(cpu_addr));
            end
            checkOutput("idle_req", 32'(mem_req), 32'd0);
            checkOutput("idle_maddr", mem_addr, 32'd0);
            checkOutput("idle_miss", 32'(miss_cnt), 32'(mmiss));
            if (flush) begin
                for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
            end else if (!hitm) begin
                refilling = 1'b1;
                mbase     = cpu_addr & ~32'(WORDS - 1);
                mgot      = 0;
                if (mmiss < 65535) mmiss++;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic fl, input logic ack);
        @(posedge clk);
        #1;
        cpu_addr = addr;
        flush    = fl;
        mem_ack  = ack;
    endtask

    // Presents addr from the miss cycle onwards; reports cycles until cpu_ready, or -1 on timeout.
    task automatic runUntilReady(input logic [31:0] addr, input bit alt, output int cycles);
        cycles = -1;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(addr, 1'b0, alt ? logic'(k % 2 == 0) : 1'b1);
            #2;
            if (cpu_ready) begin
                cycles = k;
                break;
            end
        end
        if (cycles < 0) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int p;
        rst_n    = 1'b0;
        cpu_addr = '0;
        flush    = 1'b0;
        mem_ack  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        rst_n = 1'b1;

        // Cold fetch of word 0: five stall cycles, refill of words 0..3, then a hit.
        for (int k = 0; k <= 5; k++) begin
            applyStimulus(32'h0, 1'b0, 1'b1);
            #2;
            if (k < 5) checkOutput("cold_stall", 32'(cpu_ready), 32'd0);
            if (k >= 1 && k <= 4) checkOutput("cold_maddr", mem_addr, 32'(k - 1));
            if (k == 5) begin
                checkOutput("cold_ready", 32'(cpu_ready), 32'd1);
                checkOutput("cold_rdata", cpu_rdata, 32'hC0DEFFFF);
                checkOutput("cold_miss", 32'(miss_cnt), 32'd1);
            end
        end

        applyStimulus(32'h1, 1'b0, 1'b1);
        #2;
        checkOutput("hit1_ready", 32'(cpu_ready), 32'd1);
        checkOutput("hit1_rdata", cpu_rdata, 32'hC0DFFFFE);
        checkOutput("hit1_req", 32'(mem_req), 32'd0);
        applyStimulus(32'h2, 1'b0, 1'b1);
        #2;
        checkOutput("hit2_rdata", cpu_rdata, 32'hC0DCFFFD);
        applyStimulus(32'h3, 1'b0, 1'b1);
        #2;
        checkOutput("hit3_rdata", cpu_rdata, 32'hC0DDFFFC);
        checkOutput("hit_miss", 32'(miss_cnt), 32'd1);

        // Conflict on line 0.
        runUntilReady(32'h20, 1'b0, p);
        checkOutput("conf_pen", 32'(p), 32'd5);
        checkOutput("conf_rdata", cpu_rdata, 32'hC0FEFFDF);
        runUntilReady(32'h0, 1'b0, p);
        checkOutput("conf_pen2", 32'(p), 32'd5);
        checkOutput("conf_miss", 32'(miss_cnt), 32'd3);

        // Alternating ack doubles the refill time.
        runUntilReady(32'h4, 1'b1, p);
        checkOutput("bp_pen", 32'(p), 32'd9);
        checkOutput("bp_rdata", cpu_rdata, 32'hC0DAFFFB);

        // Flush after two refill words abandons the line.
        applyStimulus(32'h8, 1'b0, 1'b1);
        applyStimulus(32'h8, 1'b0, 1'b1);
        applyStimulus(32'h8, 1'b0, 1'b1);
        applyStimulus(32'h8, 1'b1, 1'b1);
        #2;
        checkOutput("fl_req", 32'(mem_req), 32'd1);
        runUntilReady(32'h8, 1'b0, p);
        checkOutput("fl_pen", 32'(p), 32'd5);
        checkOutput("fl_miss", 32'(miss_cnt), 32'd6);

        // Flush while idle on a resident line.
        applyStimulus(32'h8, 1'b1, 1'b1);
        #2;
        checkOutput("fli_ready", 32'(cpu_ready), 32'd0);
        runUntilReady(32'h8, 1'b0, p);
        checkOutput("fli_pen", 32'(p), 32'd5);
        checkOutput("fli_miss", 32'(miss_cnt), 32'd7);

        // Asynchronous reset in the middle of a refill.
        applyStimulus(32'h40, 1'b0, 1'b1);
        applyStimulus(32'h40, 1'b0, 1'b1);
        applyStimulus(32'h40, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_req", 32'(mem_req), 32'd0);
        checkOutput("ar_maddr", mem_addr, 32'd0);
        checkOutput("ar_miss", 32'(miss_cnt), 32'd0);
        checkOutput("ar_ready", 32'(cpu_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        rst_n = 1'b1;
        runUntilReady(32'h40, 1'b0, p);
        checkOutput("ar_pen", 32'(p), 32'd5);
        checkOutput("ar_miss2", 32'(miss_cnt), 32'd1);

        // Randomized fetch stream with backpressure, address churn and occasional flushes.
        begin
            logic [31:0] cur;
            cur = 32'h0;
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(0, 9) < 4) begin
                    cur = 32'($urandom_range(0, 127));
                    if ($urandom_range(0, 7) == 0) cur = cur | 32'h0001_0000;
                end
                applyStimulus(cur, logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 3) != 0));
            end
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
